// File: rtl/if_fetch_unit_pkg.sv
// Shared constants for the openmips instruction-fetch front end.
// Bus widths and the enable/stall encodings used by the pc/if_id logic.
package if_fetch_unit_pkg;

  localparam int InstAddrBusW = 32;
  localparam int InstBusW     = 32;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Synchronous prefetch queue sitting between the ROM and the ID stage.
// A push and a pop can happen in the same cycle, even when full.
// clear empties the queue and overrides any push/pop in that cycle.
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic isFull;
  logic isEmpty;
  logic doPush;
  logic doPop;

  assign isFull  = (count_q == CNT_W'(DEPTH));
  assign isEmpty = (count_q == '0);

  // A pop frees the head slot in the same cycle, so a full queue still accepts a push alongside it.
  assign doPop  = pop_i & ~isEmpty & ~clear_i;
  assign doPush = push_i & (~isFull | doPop) & ~clear_i;

  // Next pointer/occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (doPush) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (doPop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers, discarded immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC generation, ROM enable and a prefetch
// queue toward ID, with decode back-pressure and branch/exception redirect.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = InstAddrBusW,
  parameter int                INST_W   = InstBusW,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [INST_W-1:0] rom_data_i,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              id_valid_o,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic [LVL_W-1:0]  level_o
);

  localparam int ENTRY_W = ADDR_W + INST_W;

  logic              ce_q;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic [LVL_W-1:0]   fifoCount;
  logic [ENTRY_W-1:0] fifoHead;
  logic [ENTRY_W-1:0] fifoData;

  logic hasRoom;
  logic headValid;
  logic popReq;
  logic fetchEn;

  // Enable comes up one edge after reset so the first fetch sees a settled PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_q <= ChipDisable;
    end else begin
      ce_q <= ChipEnable;
    end
  end

  assign hasRoom   = (fifoCount < LVL_W'(DEPTH));
  assign headValid = (fifoCount != '0) & ~redirect_i;
  assign popReq    = headValid & (stall_i == NoStop);
  assign fetchEn   = ce_q & ~redirect_i & (hasRoom | popReq);

  // Redirect overrides everything; otherwise advance only when a fetch is accepted.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (fetchEn) begin
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  // Program counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign fifoData = {pc_q, rom_data_i};

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fetchEn),
    .pop_i   (popReq),
    .clear_i (redirect_i),
    .data_i  (fifoData),
    .head_o  (fifoHead),
    .count_o (fifoCount)
  );

  assign rom_ce_o   = fetchEn;
  assign rom_addr_o = pc_q;
  assign id_valid_o = headValid;
  assign id_pc_o    = headValid ? fifoHead[ENTRY_W-1:INST_W] : '0;
  assign id_inst_o  = headValid ? fifoHead[INST_W-1:0] : '0;
  assign level_o    = fifoCount;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a queue-based reference model predicts
// every cycle, a separate monitor compares the DUT against those predictions.
module tb_if_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPc;

  logic        romCe0, idValid0;
  logic [31:0] romAddr0, romData0, idPc0, idInst0;
  logic [2:0]  level0;

  logic        romCe1, idValid1;
  logic [31:0] romAddr1, romData1, idPc1, idInst1;
  logic [2:0]  level1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  typedef struct packed {
    logic        romCe;
    logic [31:0] romAddr;
    logic        idValid;
    logic [31:0] headPc;
    logic [2:0]  level;
  } cyc_t;

  entry_t      modelQ[$];
  entry_t      expQ[$];
  cyc_t        cycQ[$];
  logic [31:0] modelPc;
  bit          modelCe;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] romWord(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign romData0 = romWord(romAddr0);
  assign romData1 = romWord(romAddr1);

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk           (clk),
    .rst           (rst),
    .rom_ce_o      (romCe0),
    .rom_addr_o    (romAddr0),
    .rom_data_i    (romData0),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirectPc),
    .id_valid_o    (idValid0),
    .id_pc_o       (idPc0),
    .id_inst_o     (idInst0),
    .level_o       (level0)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk           (clk),
    .rst           (rst),
    .rom_ce_o      (romCe1),
    .rom_addr_o    (romAddr1),
    .rom_data_i    (romData1),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirectPc),
    .id_valid_o    (idValid1),
    .id_pc_o       (idPc1),
    .id_inst_o     (idInst1),
    .level_o       (level1)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One cycle: drive inputs at the falling edge, predict outputs, then advance the model.
  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc);
    cyc_t   rec;
    entry_t e;
    int     occ;
    bit     valid, pop, fetch;
    @(negedge clk);
    stall      = s;
    redirect   = r;
    redirectPc = rpc;
    #1;
    occ   = modelQ.size();
    valid = (occ != 0) && !r;
    pop   = valid && !s;
    fetch = modelCe && !r && ((occ < DEPTH) || pop);
    rec.romCe   = fetch;
    rec.romAddr = modelPc;
    rec.idValid = valid;
    rec.headPc  = valid ? modelQ[0].pc : 32'h0;
    rec.level   = 3'(occ);
    cycQ.push_back(rec);
    if (r) begin
      modelQ.delete();
      expQ.delete();
      modelPc = rpc;
    end else begin
      if (pop) void'(modelQ.pop_front());
      if (fetch) begin
        e.pc   = modelPc;
        e.inst = romWord(modelPc);
        modelQ.push_back(e);
        expQ.push_back(e);
        modelPc = modelPc + 32'd4;
      end
    end
    modelCe = 1'b1;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_rom_ce", 64'(romCe0), 64'(0));
    checkOutput("rst_rom_addr", 64'(romAddr0), 64'(0));
    checkOutput("rst_id_valid", 64'(idValid0), 64'(0));
    checkOutput("rst_id_pc", 64'(idPc0), 64'(0));
    checkOutput("rst_id_inst", 64'(idInst0), 64'(0));
    checkOutput("rst_level", 64'(level0), 64'(0));
    checkOutput("rst_rom_addr_wrapdut", 64'(romAddr1), 64'(32'hFFFF_FFF8));
    checkOutput("rst_id_valid_wrapdut", 64'(idValid1), 64'(0));
  endtask

  task automatic resetModel();
    modelQ.delete();
    expQ.delete();
    modelPc = 32'h0;
    modelCe = 1'b0;
  endtask

  // Assert reset between edges and check outputs before any further clock edge.
  task automatic resetDuts();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkResetOutputs();
    resetModel();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: compare each predicted cycle, and each popped instruction against the scoreboard.
  initial begin
    cyc_t   c;
    entry_t e;
    forever begin
      @(negedge clk);
      #2;
      if (cycQ.size() != 0) begin
        c = cycQ.pop_front();
        checkOutput("rom_ce", 64'(romCe0), 64'(c.romCe));
        checkOutput("rom_addr", 64'(romAddr0), 64'(c.romAddr));
        checkOutput("id_valid", 64'(idValid0), 64'(c.idValid));
        checkOutput("id_pc_head", 64'(idPc0), 64'(c.headPc));
        checkOutput("level", 64'(level0), 64'(c.level));
        if (idValid0 && !stall) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL pop_unexpected: got pc %0h, expected no instruction", idPc0);
          end else begin
            e = expQ.pop_front();
            checkOutput("pop_pc", 64'(idPc0), 64'(e.pc));
            checkOutput("pop_inst", 64'(idInst0), 64'(e.inst));
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] wrapAddr [4];
    logic        s, r;
    logic [31:0] rpc;
    wrapAddr = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    rst        = 1'b1;
    stall      = 1'b0;
    redirect   = 1'b0;
    redirectPc = 32'h0;
    resetModel();
    #3;
    checkResetOutputs();
    @(posedge clk);
    #2;
    rst = 1'b0;

    $display("[TB] sequential fetch and PC wrap");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0);
      if (i < 4) checkOutput($sformatf("wrap_addr_%0d", i), 64'(romAddr1), 64'(wrapAddr[i]));
      if (i == 2) begin
        checkOutput("wrap_id_valid", 64'(idValid1), 64'(1));
        checkOutput("wrap_id_pc", 64'(idPc1), 64'(32'hFFFF_FFF8));
      end
    end

    $display("[TB] stall until full, then drain");
    repeat (8) applyStimulus(1'b1, 1'b0, 32'h0);
    repeat (6) applyStimulus(1'b0, 1'b0, 32'h0);

    $display("[TB] full queue with toggling stall");
    repeat (6) applyStimulus(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) applyStimulus(1'(i % 2), 1'b0, 32'h0);

    $display("[TB] redirect at partial occupancy");
    applyStimulus(1'b0, 1'b1, 32'h0000_0200);
    repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0100);
    repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);

    $display("[TB] redirect with stall at full");
    repeat (6) applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0340);
    repeat (4) applyStimulus(1'b0, 1'b0, 32'h0);

    $display("[TB] randomized traffic with mid-stream reset");
    for (int i = 0; i < 400; i++) begin
      s   = ($urandom_range(0, 99) < 35);
      r   = ($urandom_range(0, 99) < 6);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : $urandom;
      applyStimulus(s, r, rpc);
      if (i == 200) resetDuts();
    end

    @(negedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the openmips pipeline.
- Merges PC generation and the IF/ID boundary into one block with a DEPTH-entry prefetch queue.
- Adds decode back-pressure (stall) and branch/exception redirect, which the current pc_reg/if_id pair lacks.
- Sits between the instruction ROM and the ID stage.

Parameters:
- ADDR_W, 32, instruction address width
- INST_W, 32, instruction word width
- DEPTH, 4, prefetch queue entries; power of two, >=2
- RESET_PC, 0, PC value after reset
- PC_STEP, 4, sequential PC increment in bytes

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous active-high reset
- rom_ce_o  out  1  ROM enable; a fetch occurs in every cycle this is 1
- rom_addr_o  out  ADDR_W  fetch address (current PC)
- rom_data_i  in  INST_W  instruction word; combinational ROM, valid in the same cycle as rom_addr_o
- stall_i  in  1  ID not ready; head is held
- redirect_i  in  1  branch taken or exception flush
- redirect_pc_i  in  ADDR_W  new fetch PC, used as-is with no alignment masking
- id_valid_o  out  1  id_pc_o/id_inst_o carry a valid instruction
- id_pc_o  out  ADDR_W  PC of queue head
- id_inst_o  out  INST_W  instruction at queue head
- level_o  out  clog2(DEPTH)+1  queue occupancy

Behaviour:
Reset (asynchronous, immediate):
- pc=RESET_PC, ce_q=0, count=0, read/write pointers=0.
- Outputs: rom_ce_o=0, rom_addr_o=RESET_PC, id_valid_o=0, id_pc_o=0, id_inst_o=0, level_o=0.

Enable:
- ce_q sets to 1 on the first rising edge after rst deasserts.
- rom_ce_o = ce_q & !redirect_i & (count<DEPTH | pop).
- rom_addr_o = pc at all times.

Push:
- When rom_ce_o=1, write {pc, rom_data_i} at the write pointer, then pc <= pc+PC_STEP.
- The PC wraps modulo 2^ADDR_W.

Pop:
- pop = id_valid_o & !stall_i; the read pointer advances.
- id_valid_o = (count!=0) & !redirect_i.
- id_pc_o/id_inst_o show the head entry when id_valid_o=1, otherwise 0.

Latency:
- An instruction fetched in cycle N is first visible on id_* in cycle N+1.
- There is no same-cycle bypass.
- Sustained throughput is 1 instruction/cycle while stall_i=0.

Redirect (highest priority):
- When redirect_i=1 at an edge: count <= 0, both pointers <= 0, pc <= redirect_pc_i.
- No push and no pop that cycle.
- Fetch at redirect_pc_i occurs in cycle N+1; its first id_valid_o is in N+2.

Boundaries:
- Full, no pop: rom_ce_o=0 and pc holds.
- Full with pop in the same cycle: push is allowed, so occupancy stays at DEPTH.
- Empty: pop is impossible; a push alone raises count to 1.
- Pointers wrap at DEPTH.
- count never exceeds DEPTH or drops below 0.
- stall_i with redirect_i: redirect wins.
- rst asserted mid-operation: all state is discarded immediately, with no pending writes.

Decomposition:
- Shared package (defines file): ZeroWord, InstAddrBus/InstBus widths, ChipEnable/ChipDisable, Stop/NoStop constants. No new typedefs are needed.
- Sub-module fetch_fifo: synchronous FIFO parametrised by width (ADDR_W+INST_W) and DEPTH.
  - push/pop/clear inputs; head/count outputs.
  - clear takes priority over push/pop.
- PC and enable logic stay in if_fetch_unit.

Test Plan:
- Reset release, stall_i=0, ROM word=addr: rom_addr_o sequence 0,4,8,...; id_pc_o 0,4,8 starting 1 cycle later; id_valid_o held at 1; level_o=1.
- stall_i=1 from cycle 3:
  - level_o climbs to 4, then rom_ce_o=0 and rom_addr_o frozen.
  - id_pc_o holds its value.
  - On release, entries drain in order with no gap or duplicate.
- Full queue with stall_i toggling every cycle: simultaneous push/pop keeps level_o at 4 or 3; the id_pc_o sequence remains strictly +4.
- redirect_i pulse with redirect_pc_i=0x100 while level_o=3:
  - id_valid_o=0 that cycle.
  - Next cycle rom_addr_o=0x100, level_o=0.
  - Following cycle id_pc_o=0x100.
- redirect_i together with stall_i=1 at full: redirect wins; the queue is cleared and fetch restarts at redirect_pc_i.
- RESET_PC=0xFFFFFFF8: PC wraps 0xFFFFFFF8, 0xFFFFFFFC, 0x0. Asserting rst mid-stream forces all outputs to their reset values asynchronously, before the next edge.
